// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller with HI/LO registers.
//
// Models a multi-cycle MDU. The 64-bit result is computed when the operation
// is accepted and parked in temp. It is committed to HI/LO only after the
// configured latency has elapsed. While the unit is occupied it raises busy.
// stall_D asks the front of the pipeline to freeze whenever the D-stage
// instruction needs the MDU.
//
// Optional feature: define MDU_DIV0_FAST_EN to make div/divu by zero finish
// in the start cycle. In that case the FSM stays IDLE, busy stays low and
// HI/LO are untouched. Without the macro a divide by zero occupies the unit
// for the full divide latency and then leaves HI/LO unchanged.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   E_mdOp   in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   E_start  in   1   E stage holds a valid MDU instruction this cycle
//   E_rsVal  in  32   forwarded rs operand (dividend / multiplicand / mthi-mtlo data)
//   E_rtVal  in  32   forwarded rt operand (divisor / multiplier)
//   D_useMd  in   1   D-stage instruction touches the MDU or HI/LO
//   busy     out  1   MDU occupied
//   stall_D  out  1   freeze PC/F/D and bubble E
//   hi       out 32   HI register
//   lo       out 32   LO register
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  E_mdOp,
    input  logic        E_start,
    input  logic [31:0] E_rsVal,
    input  logic [31:0] E_rtVal,
    input  logic        D_useMd,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_BITS   = $clog2(MAX_CYCLES + 1);
    localparam int CNT_W      = (CNT_BITS > 4) ? CNT_BITS : 4;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

`ifdef MDU_DIV0_FAST_EN
    localparam logic DIV0_FAST = 1'b1;
`else
    localparam logic DIV0_FAST = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    // Full 64-bit product. Sign- or zero-extending to 64 bits first makes
    // the low 64 bits of the product correct for both signednesses.
    function automatic logic [63:0] mul_full(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_signed);
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return a_ext * b_ext;
    endfunction

    // Returns {remainder, quotient}. The signed case divides the magnitudes
    // and then restores the signs. The quotient truncates toward zero and
    // the remainder follows the dividend. This also yields 0x80000000 / -1
    // = 0x80000000 with remainder 0, with no overflow special case. A zero
    // divisor returns zeros; the caller suppresses the commit anyway.
    function automatic logic [63:0] div_full(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_signed);
        logic        neg_q;
        logic        neg_r;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        neg_q = is_signed & (a[31] ^ b[31]);
        neg_r = is_signed & a[31];
        mag_a = (is_signed & a[31]) ? (~a + 32'd1) : a;
        mag_b = (is_signed & b[31]) ? (~b + 32'd1) : b;
        if (mag_b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mag_a / mag_b;
            r = mag_a % mag_b;
        end
        if (neg_q) q = ~q + 32'd1;
        if (neg_r) r = ~r + 32'd1;
        return {r, q};
    endfunction

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [63:0]      temp_q,   temp_d;
    logic             commit_q, commit_d;  // low when the pending result must not reach HI/LO
    logic [31:0]      hi_q,     hi_d;
    logic [31:0]      lo_q,     lo_d;

    logic op_mul;
    logic op_div;
    logic div_skip;
    logic long_start;

    assign op_mul     = (E_mdOp == 3'd1) || (E_mdOp == 3'd2);
    assign op_div     = (E_mdOp == 3'd3) || (E_mdOp == 3'd4);
    assign div_skip   = DIV0_FAST && op_div && (E_rtVal == 32'd0);
    assign long_start = E_start && (state_q == IDLE) && (op_mul || (op_div && !div_skip));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        temp_d   = temp_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (E_start) begin
                    case (E_mdOp)
                        3'd1, 3'd2: begin
                            temp_d   = mul_full(E_rsVal, E_rtVal, E_mdOp == 3'd1);
                            cnt_d    = MULT_CNT;
                            commit_d = 1'b1;
                            state_d  = MUL;
                        end
                        3'd3, 3'd4: begin
                            if (!div_skip) begin
                                temp_d   = div_full(E_rsVal, E_rtVal, E_mdOp == 3'd3);
                                cnt_d    = DIV_CNT;
                                commit_d = (E_rtVal != 32'd0);
                                state_d  = DIV;
                            end
                        end
                        3'd5:    hi_d = E_rsVal;
                        3'd6:    lo_d = E_rsVal;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                // Starts arriving here are ignored: only the countdown runs.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (commit_q) begin
                        hi_d = temp_q[63:32];
                        lo_d = temp_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            temp_q   <= '0;
            commit_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            temp_q   <= temp_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // busy covers the start cycle combinationally so the stall starts at once.
    assign busy    = long_start || (state_q != IDLE);
    assign stall_D = D_useMd && busy;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a transaction-level HI/LO model with
// absolute completion edges, checked every cycle, plus literal expectations.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_DIV0_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [2:0]  E_mdOp;
    logic        E_start;
    logic [31:0] E_rsVal;
    logic [31:0] E_rtVal;
    logic        D_useMd;
    logic        busy;
    logic        stall_D;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .E_mdOp  (E_mdOp),
        .E_start (E_start),
        .E_rsVal (E_rsVal),
        .E_rtVal (E_rtVal),
        .D_useMd (D_useMd),
        .busy    (busy),
        .stall_D (stall_D),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural HI/LO plus one outstanding result that
    // lands at an absolute edge number.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_active, p_commit;
    longint      edge_no, done_edge;
    bit          last_busy, last_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    function automatic bit exp_busy();
        bit is_long;
        is_long = (E_mdOp == 3'd1) || (E_mdOp == 3'd2) ||
                  (((E_mdOp == 3'd3) || (E_mdOp == 3'd4)) && !(FAST && (E_rtVal == 32'd0)));
        return m_active || (E_start && is_long);
    endfunction

    task automatic compare();
        bit eb;
        eb = exp_busy();
        check("busy",    32'(busy),    32'(eb));
        check("stall_D", 32'(stall_D), 32'(D_useMd && eb));
        check("hi",      hi,           m_hi);
        check("lo",      lo,           m_lo);
    endtask

    task automatic pend(input logic [31:0] h, input logic [31:0] l, input bit c, input int n);
        p_hi      = h;
        p_lo      = l;
        p_commit  = c;
        m_active  = 1'b1;
        done_edge = edge_no + longint'(n);
    endtask

    task automatic model_edge();
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, prod;
        if (!rst_n) return;
        edge_no++;
        if (m_active) begin
            if (edge_no == done_edge) begin
                m_active = 1'b0;
                if (p_commit) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else if (E_start) begin
            sa = longint'($signed(E_rsVal));
            sb = longint'($signed(E_rtVal));
            ua = {32'd0, E_rsVal};
            ub = {32'd0, E_rtVal};
            case (E_mdOp)
                3'd1: begin
                    prod = 64'(sa * sb);
                    pend(prod[63:32], prod[31:0], 1'b1, MC);
                end
                3'd2: begin
                    prod = ua * ub;
                    pend(prod[63:32], prod[31:0], 1'b1, MC);
                end
                3'd3: begin
                    if (sb == 0) begin
                        if (!FAST) pend(32'd0, 32'd0, 1'b0, DC);
                    end else begin
                        q = sa / sb;
                        r = sa % sb;
                        pend(r[31:0], q[31:0], 1'b1, DC);
                    end
                end
                3'd4: begin
                    if (ub == 0) begin
                        if (!FAST) pend(32'd0, 32'd0, 1'b0, DC);
                    end else begin
                        prod = ua / ub;
                        q    = longint'(ua % ub);
                        pend(q[31:0], prod[31:0], 1'b1, DC);
                    end
                end
                3'd5:    m_hi = E_rsVal;
                3'd6:    m_lo = E_rsVal;
                default: ;
            endcase
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        compare();
        last_busy  = busy;
        last_stall = stall_D;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset(input int n);
        E_start  = 1'b0;
        rst_n    = 1'b0;
        m_hi     = '0;
        m_lo     = '0;
        m_active = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic use_md, output int nbusy, output int nstall);
        nbusy   = 0;
        nstall  = 0;
        E_mdOp  = op;
        E_rsVal = rs;
        E_rtVal = rt;
        E_start = 1'b1;
        D_useMd = use_md;
        step();
        if (last_busy)  nbusy++;
        if (last_stall) nstall++;
        E_start = 1'b0;
        E_mdOp  = 3'd0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!last_busy) break;
            nbusy++;
            if (last_stall) nstall++;
        end
        D_useMd = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15)) - 32'd8;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int nb, ns;
        E_mdOp    = 3'd0;
        E_start   = 1'b0;
        E_rsVal   = '0;
        E_rtVal   = '0;
        D_useMd   = 1'b0;
        edge_no   = 0;
        done_edge = 0;
        p_hi      = '0;
        p_lo      = '0;
        p_commit  = 1'b0;
        apply_reset(3);
        check("reset_hi",   hi,         32'd0);
        check("reset_lo",   lo,         32'd0);
        check("reset_busy", 32'(busy),  32'd0);

        // Signed and unsigned multiply of the same operands.
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, nb, ns);
        check("mult_busy_cycles", 32'(nb), 32'(MC + 1));
        check("mult_hi",       hi,   32'hFFFF_FFFF);
        check("mult_lo",       lo,   32'hFFFF_FFFE);
        check("model_mult_hi", m_hi, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, nb, ns);
        check("multu_hi",       hi,   32'h0000_0001);
        check("multu_lo",       lo,   32'hFFFF_FFFE);
        check("model_multu_hi", m_hi, 32'h0000_0001);

        // Signed divide with the D stage waiting on the MDU.
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, nb, ns);
        check("div_stall_cycles", 32'(ns), 32'(DC + 1));
        check("div_busy_cycles",  32'(nb), 32'(DC + 1));
        check("div_lo",       lo,   32'hFFFF_FFFD);
        check("div_hi",       hi,   32'hFFFF_FFFF);
        check("model_div_lo", m_lo, 32'hFFFF_FFFD);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, ns);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        // mthi/mtlo, then an unsigned divide by zero.
        run_op(3'd5, 32'h0000_0012, 32'd0, 1'b0, nb, ns);
        check("mthi_busy", 32'(nb), 32'd0);
        run_op(3'd6, 32'h0000_0034, 32'd0, 1'b0, nb, ns);
        run_op(3'd4, 32'h0000_0055, 32'd0, 1'b1, nb, ns);
        check("div0_busy_cycles", 32'(nb), FAST ? 32'd0 : 32'(DC + 1));
        check("div0_hi", hi, 32'h0000_0012);
        check("div0_lo", lo, 32'h0000_0034);

        // Reset in the middle of a multiply aborts it.
        E_mdOp = 3'd1; E_rsVal = 32'd3; E_rtVal = 32'd4; E_start = 1'b1;
        step();
        E_start = 1'b0; E_mdOp = 3'd0;
        step();
        apply_reset(1);
        check("abort_hi",   hi,        32'd0);
        check("abort_lo",   lo,        32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (12) step();
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);
        // The first edge after release accepts a start.
        run_op(3'd2, 32'd3, 32'd4, 1'b0, nb, ns);
        check("post_reset_busy", 32'(nb), 32'(MC + 1));
        check("post_reset_lo",   lo,      32'd12);

        // mthi while a multiply is running is dropped; in IDLE it lands.
        E_mdOp = 3'd1; E_rsVal = 32'h10; E_rtVal = 32'h10; E_start = 1'b1;
        step();
        E_mdOp = 3'd5; E_rsVal = 32'hDEAD_BEEF;
        step();
        E_start = 1'b0; E_mdOp = 3'd0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!last_busy) break;
        end
        check("busy_mthi_hi", hi, 32'd0);
        check("busy_mthi_lo", lo, 32'h100);
        run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, nb, ns);
        check("idle_mthi_hi", hi, 32'hDEAD_BEEF);
        check("idle_mthi_lo", lo, 32'h100);

        // Randomised traffic, including starts while busy and odd resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset(int'($urandom_range(1, 2)));
                continue;
            end
            E_start = ($urandom_range(0, 2) == 0);
            E_mdOp  = 3'($urandom_range(0, 7));
            E_rsVal = pick();
            E_rtVal = pick();
            D_useMd = $urandom_range(0, 1) == 1;
            step();
        end
        E_start = 1'b0;
        D_useMd = 1'b0;
        repeat (DC + 2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
